led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Autonomous LED pattern engine that drives the 8-bit LED PIO slave through its Avalon-MM write port, so the Nios II CPU does not need to bit-bang patterns. The CPU programs it through a small Avalon-MM slave: enable, mode, step period and seed pattern. The block sits between the CPU bus and the LED PIO s1 port and is the only master writing that PIO.

Parameters:
LED_W, 8, LED/pattern width; must be at most 32.
PERIOD_W, 24, width of the step-period register and counter.
RESET_PERIOD, 24'd50_000_000, PERIOD value after reset (1 s at 50 MHz).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_address  in  2  CPU slave register index
s_chipselect  in  1  CPU slave select
s_write_n  in  1  CPU write strobe, active low
s_writedata  in  32  CPU write data
s_readdata  out  32  CPU read data, combinational from s_address
pio_address  out  2  to PIO s1 address; always 0
pio_chipselect  out  1  to PIO s1 chipselect
pio_write_n  out  1  to PIO s1 write_n
pio_writedata  out  32  to PIO s1 writedata, {zero-pad, pattern}
irq  out  1  step-wrap interrupt; see Optional Feature

Behaviour:
- Registers:
  - 0 CTRL: bit0 EN, bit1 MODE (0 = rotate-left, 1 = bounce).
  - 1 PERIOD: [PERIOD_W-1:0]; a write of 0 is stored as 1.
  - 2 PATTERN: write loads the seed and current pattern; read returns the current pattern.
  - 3 STATUS: bit0 BUSY (state != IDLE), bit1 DIR (0 = left), bit2 WRAP (sticky).
  - Unused bits read 0.
- Reset values: CTRL=0, PERIOD=RESET_PERIOD, seed=pattern=0, DIR=0, WRAP=0, counter=0, state IDLE, pio_chipselect=0, pio_write_n=1, pio_writedata=0, irq=0.
- A CPU write occurs when s_chipselect=1 and s_write_n=0; it takes effect on that clk edge.
- FSM states: IDLE, COUNT, WRITE.
  - IDLE: if EN=1, load counter = PERIOD-1 and go to COUNT.
  - COUNT: decrement each cycle. At counter==0, compute the next pattern and go to WRITE. If EN=0, go to IDLE immediately, with no write.
  - WRITE: assert pio_chipselect=1 and pio_write_n=0 for exactly one cycle, with pio_writedata holding the new pattern. Reload the counter and return to COUNT, or to IDLE if EN=0.
  - The step interval is exactly PERIOD+1 cycles from one WRITE pulse to the next.
- Next-pattern arithmetic:
  - Rotate mode: rotate left by 1 within LED_W bits; MSB wraps to LSB.
  - Bounce mode: shift in direction DIR, no wrap. When the shifted pattern would lose its set MSB (left) or LSB (right), toggle DIR and shift the other way instead.
  - A pattern of 0 stays 0, but a WRITE still issues.
  - An all-ones pattern is unchanged in both modes.
- WRAP sets when the next pattern equals the seed and the seed is nonzero. Any write to STATUS clears it.
- PATTERN write:
  - Loads seed and pattern, clears DIR, and forces a WRITE on the next cycle regardless of EN.
  - The counter then restarts from PERIOD-1; from IDLE (EN=0), the block returns to IDLE.
  - If a PATTERN write coincides with counter==0, the CPU value wins and the computed step is discarded.
- Writing PERIOD mid-count does not alter the running counter; the new value is used at the next reload.
- Clearing EN while in WRITE lets that write complete.
- Reset mid-operation aborts any PIO write immediately (outputs go to reset values) with no glitch pulse.

Optional Feature:
LED_SEQ_STEP_IRQ_EN:
- Defined: irq = WRAP & CTRL bit2 (IRQ_EN, writable). irq is level, registered, and cleared by a STATUS write.
- Undefined: CTRL bit2 reads 0 and is ignored, and irq is tied to 0. WRAP still reports in STATUS.

Test Plan:
1. Reset, then read all registers -> CTRL=0, PERIOD=RESET_PERIOD, PATTERN=0, STATUS=0; pio_chipselect=0, pio_write_n=1.
2. PERIOD=3, PATTERN=0x81, CTRL=1 -> immediate PIO write 0x81, then writes 0x03, 0x06, 0x0C, each exactly 4 cycles apart.
3. MODE=1, PATTERN=0x40, PERIOD=1 -> PIO sequence 0x80, 0x40, 0x20; 0x80 then 0x40 shows DIR toggling at the MSB. At 0x01 the next value is 0x02.
4. PATTERN=0x01, rotate mode, LED_SEQ_STEP_IRQ_EN defined, IRQ_EN=1 -> after 8 steps WRAP=1 and irq=1. A STATUS write clears both in the next cycle.
5. PERIOD=0 written -> reads back 1, with writes 2 cycles apart. Clearing EN mid-COUNT -> no further PIO writes, BUSY=0 within 1 cycle.
6. PATTERN write on the counter==0 cycle -> the PIO receives the CPU value, not the computed step. Asserting reset during WRITE -> pio_chipselect drops the same cycle and all registers return to reset values.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Autonomous LED pattern engine. The CPU programs enable, mode, step period
// and a seed pattern through a small Avalon-MM slave; the block then steps the
// pattern on its own and pushes every new value into the LED PIO s1 port with
// a single-cycle Avalon-MM write. It is the only master writing that PIO.
//
// Register map (s_address):
//   0 CTRL    bit0 EN, bit1 MODE (0 rotate-left, 1 bounce), bit2 IRQ_EN
//   1 PERIOD  [PERIOD_W-1:0] step period; a written 0 is stored as 1
//   2 PATTERN write: seed + current pattern (forces a PIO write);
//             read: current pattern
//   3 STATUS  bit0 BUSY, bit1 DIR (0 = left), bit2 WRAP (sticky);
//             any write clears WRAP
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   s_address         CPU slave register index
//   s_chipselect      CPU slave select
//   s_write_n         CPU write strobe, active low
//   s_writedata       CPU write data
//   s_readdata        CPU read data, combinational from s_address
//   pio_address       PIO s1 address, always 0
//   pio_chipselect    PIO s1 chipselect
//   pio_write_n       PIO s1 write_n
//   pio_writedata     PIO s1 writedata, zero-padded pattern
//   irq               step-wrap interrupt (level, registered)
//
// Build option:
//   LED_SEQ_STEP_IRQ_EN  when defined, CTRL bit2 (IRQ_EN) is writable and
//                        irq = WRAP & IRQ_EN. When undefined, CTRL bit2 reads
//                        0 and irq is tied low; WRAP still shows in STATUS.
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int              LED_W        = 8,
    parameter int              PERIOD_W     = 24,
    parameter longint unsigned RESET_PERIOD = 64'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        irq
);

    // One second at 50 MHz does not fit in a 24-bit period register, so the
    // reset period saturates at the largest value the register can hold.
    // A zero reset period would break the PERIOD-1 reload, so it becomes 1.
    localparam longint unsigned PERIOD_MAX  = (64'd1 << PERIOD_W) - 64'd1;
    localparam longint unsigned PERIOD_SAT  = (RESET_PERIOD > PERIOD_MAX) ? PERIOD_MAX :
                                              ((RESET_PERIOD == 64'd0) ? 64'd1 : RESET_PERIOD);
    localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(PERIOD_SAT);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE  = PERIOD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] period_reg;
    logic [LED_W-1:0]    seed;
    logic [LED_W-1:0]    pattern;
    logic                dir;
    logic                wrap;
    logic                ctrl_en;
    logic                ctrl_mode;
    logic                ctrl_irq_en;

    logic                cpu_write;
    logic                wr_ctrl;
    logic                wr_period;
    logic                wr_pattern;
    logic                wr_status;
    logic [PERIOD_W-1:0] period_wdata;
    logic [LED_W-1:0]    step_pattern;
    logic                step_dir;
    logic                step_due;
    logic                wrap_set;
    logic                wrap_next;

    // Upper write-data bits have no register behind them.
    logic                unused_writedata;

    assign unused_writedata = &{1'b0, s_writedata};

    assign cpu_write    = s_chipselect & ~s_write_n;
    assign wr_ctrl      = cpu_write && (s_address == 2'd0);
    assign wr_period    = cpu_write && (s_address == 2'd1);
    assign wr_pattern   = cpu_write && (s_address == 2'd2);
    assign wr_status    = cpu_write && (s_address == 2'd3);
    assign period_wdata = s_writedata[PERIOD_W-1:0];
    assign pio_address  = 2'b00;

    // The step fires on the last COUNT cycle; a simultaneous PATTERN write
    // discards it, so WRAP must not see the discarded value either.
    assign step_due  = (state == COUNT) && ctrl_en && (counter == '0);
    assign wrap_set  = step_due && !wr_pattern && (step_pattern == seed) && (seed != '0);
    assign wrap_next = (wrap && !wr_status) || wrap_set;

    // Next pattern. Zero and all-ones are fixed points in both modes. In
    // bounce mode a shift that would push a set bit off the end reverses
    // direction and shifts the other way instead.
    always_comb begin
        step_pattern = pattern;
        step_dir     = dir;
        if ((pattern != '0) && (pattern != '1)) begin
            if (!ctrl_mode) begin
                step_pattern = {pattern[LED_W-2:0], pattern[LED_W-1]};
            end else if (!dir) begin
                if (pattern[LED_W-1]) begin
                    step_dir     = 1'b1;
                    step_pattern = pattern >> 1;
                end else begin
                    step_pattern = pattern << 1;
                end
            end else begin
                if (pattern[0]) begin
                    step_dir     = 1'b0;
                    step_pattern = pattern << 1;
                end else begin
                    step_pattern = pattern >> 1;
                end
            end
        end
    end

`ifdef LED_SEQ_STEP_IRQ_EN
    logic irq_en_next;

    assign irq_en_next = wr_ctrl ? s_writedata[2] : ctrl_irq_en;
`else
    assign ctrl_irq_en = 1'b0;
    assign irq         = 1'b0;
`endif

    // Control registers, sequencer FSM and the registered PIO master outputs.
    // A PATTERN write overrides whatever the FSM was doing and forces a PIO
    // write next cycle; the counter is reloaded when that write retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            period_reg     <= PERIOD_INIT;
            seed           <= '0;
            pattern        <= '0;
            dir            <= 1'b0;
            wrap           <= 1'b0;
            ctrl_en        <= 1'b0;
            ctrl_mode      <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
`ifdef LED_SEQ_STEP_IRQ_EN
            ctrl_irq_en    <= 1'b0;
            irq            <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= s_writedata[0];
                ctrl_mode <= s_writedata[1];
            end
            if (wr_period) begin
                period_reg <= (period_wdata == '0) ? PERIOD_ONE : period_wdata;
            end
            wrap <= wrap_next;
`ifdef LED_SEQ_STEP_IRQ_EN
            ctrl_irq_en <= irq_en_next;
            irq         <= wrap_next && irq_en_next;
`endif

            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;

            if (wr_pattern) begin
                seed           <= s_writedata[LED_W-1:0];
                pattern        <= s_writedata[LED_W-1:0];
                dir            <= 1'b0;
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= 32'(s_writedata[LED_W-1:0]);
                state          <= WRITE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrl_en) begin
                            counter <= period_reg - PERIOD_ONE;
                            state   <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (!ctrl_en) begin
                            state <= IDLE;
                        end else if (counter == '0) begin
                            pattern        <= step_pattern;
                            dir            <= step_dir;
                            pio_chipselect <= 1'b1;
                            pio_write_n    <= 1'b0;
                            pio_writedata  <= 32'(step_pattern);
                            state          <= WRITE;
                        end else begin
                            counter <= counter - PERIOD_ONE;
                        end
                    end
                    WRITE: begin
                        counter <= period_reg - PERIOD_ONE;
                        state   <= ctrl_en ? COUNT : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // CPU read mux; unused bits read as zero.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0: begin
                s_readdata[0] = ctrl_en;
                s_readdata[1] = ctrl_mode;
                s_readdata[2] = ctrl_irq_en;
            end
            2'd1: s_readdata = 32'(period_reg);
            2'd2: s_readdata = 32'(pattern);
            2'd3: begin
                s_readdata[0] = (state != IDLE);
                s_readdata[1] = dir;
                s_readdata[2] = wrap;
            end
            default: s_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
//
// Self-checking bench for led_pattern_sequencer (default parameters). A
// behavioural model tracks the programmed registers and the absolute cycle
// at which the next PIO write is due; a compare process checks every PIO
// output, irq and the CPU read data against it on each falling edge. Directed
// sequences pin literal values; a randomized phase then exercises mixes of
// register writes.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    localparam int unsigned MASK            = 32'h0000_00FF;
    localparam int unsigned RESET_PERIOD_EX = 32'h00FF_FFFF;
`ifdef LED_SEQ_STEP_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [1:0]  s_address    = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n    = 1'b1;
    logic [31:0] s_writedata  = 32'd0;
    logic [31:0] s_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        irq;

    int     errors = 0;
    int     checks = 0;
    longint tb_cyc = 0;

    // Model state
    bit          m_en = 0, m_mode = 0, m_irq_en = 0, m_dir = 0, m_wrap = 0, m_irq = 0;
    bit          m_counting = 0, m_writing = 0;
    int unsigned m_period = RESET_PERIOD_EX, m_seed = 0, m_pat = 0, m_wdata = 0;
    longint      m_cyc = 0, m_due = 0;

    led_pattern_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .pio_address   (pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n   (pio_write_n),
        .pio_writedata (pio_writedata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        tb_cyc = tb_cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Next pattern from the stepping rules: a bounce shift that drops a set
    // bit (popcount falls) reverses instead.
    function automatic int unsigned next_pattern(input int unsigned p, input bit mode,
                                                 input bit dir, output bit ndir);
        int unsigned l, r;
        ndir = dir;
        if (p == 0 || p == MASK) return p;
        if (!mode) return ((p << 1) | (p >> 7)) & MASK;
        l = (p << 1) & MASK;
        r = p >> 1;
        if (!dir) begin
            if ($countones(l) < $countones(p)) begin ndir = 1; return r; end
            return l;
        end
        if ($countones(r) < $countones(p)) begin ndir = 0; return l; end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_irq_en, m_mode, m_en};
            2'd1:    return m_period;
            2'd2:    return m_pat;
            default: return {29'd0, m_wrap, m_dir, (m_counting || m_writing)};
        endcase
    endfunction

    // Model: each step is scheduled at an absolute cycle (PERIOD+1 after the
    // previous write, or PERIOD after leaving idle) rather than counted down.
    task automatic model_update();
        bit wr, set_wrap, nd;
        int unsigned np;
        if (reset) begin
            m_en = 0; m_mode = 0; m_irq_en = 0; m_dir = 0; m_wrap = 0; m_irq = 0;
            m_counting = 0; m_writing = 0; m_period = RESET_PERIOD_EX;
            m_seed = 0; m_pat = 0; m_wdata = 0; m_cyc = 0; m_due = 0;
            return;
        end
        m_cyc    = m_cyc + 1;
        wr       = s_chipselect && !s_write_n;
        set_wrap = 0;
        if (wr && s_address == 2'd2) begin
            m_seed = s_writedata & MASK; m_pat = m_seed; m_dir = 0;
            m_wdata = m_pat; m_writing = 1; m_counting = 0;
        end else if (m_writing) begin
            m_writing = 0; m_counting = m_en; m_due = m_cyc + m_period;
        end else if (m_counting) begin
            if (!m_en) m_counting = 0;
            else if (m_cyc == m_due) begin
                np = next_pattern(m_pat, m_mode, m_dir, nd);
                if (np == m_seed && m_seed != 0) set_wrap = 1;
                m_pat = np; m_dir = nd; m_wdata = np;
                m_writing = 1; m_counting = 0;
            end
        end else if (m_en) begin
            m_counting = 1; m_due = m_cyc + m_period;
        end
        m_wrap = (m_wrap && !(wr && s_address == 2'd3)) || set_wrap;
        if (wr && s_address == 2'd0) begin
            m_en = s_writedata[0]; m_mode = s_writedata[1];
            if (IRQ_BUILD) m_irq_en = s_writedata[2];
        end
        if (wr && s_address == 2'd1)
            m_period = (s_writedata[23:0] == 24'd0) ? 1 : int'(s_writedata[23:0]);
        m_irq = m_wrap && m_irq_en;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_update();
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        checkOutput("cmp_pio_chipselect", pio_chipselect, m_writing);
        checkOutput("cmp_pio_write_n", pio_write_n, !m_writing);
        checkOutput("cmp_pio_writedata", pio_writedata, m_wdata);
        checkOutput("cmp_pio_address", pio_address, 0);
        checkOutput("cmp_irq", irq, m_irq);
        checkOutput("cmp_readdata", s_readdata, model_read(s_address));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
        tick();
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_write(input string name, output logic [31:0] data, output longint when);
        bit seen = 0;
        data = '0; when = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
                data = pio_writedata; when = tb_cyc; seen = 1;
            end
            tick();
        end
        if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int n);
        logic [1:0]  a;
        logic [31:0] d;
        int unsigned r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 19);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            s_chipselect = 1'b0; s_write_n = 1'b1;
            if (r < 3) begin
                case (a)
                    2'd0: d[0] = ($urandom_range(0, 4) != 0);
                    2'd1: d[23:0] = 24'($urandom_range(0, 6));
                    2'd2: if ($urandom_range(0, 5) == 0) d[7:0] = 8'hFF;
                    default: ;
                endcase
                s_chipselect = 1'b1; s_write_n = 1'b0;
            end else if (r == 3) begin
                s_chipselect = 1'b1;
            end else if (r == 4) begin
                s_write_n = 1'b0;
            end
            s_address = a; s_writedata = d;
            tick();
        end
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    logic [31:0] rd, wd;
    longint      t0, t1;
    int          pulses;

    initial begin
        logic [31:0] exp_seq[9];
        exp_seq = '{32'h80, 32'h40, 32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01, 32'h02};

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();

        // Reset state
        cpu_read(2'd0, rd); checkOutput("reset_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); checkOutput("reset_period", rd, RESET_PERIOD_EX);
        cpu_read(2'd2, rd); checkOutput("reset_pattern", rd, 32'h0);
        cpu_read(2'd3, rd); checkOutput("reset_status", rd, 32'h0);
        checkOutput("reset_pio_cs", pio_chipselect, 0);
        checkOutput("reset_pio_wn", pio_write_n, 1);

        // Rotate: 0x81 then 0x03, 0x06, 0x0C four cycles apart
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd2, 32'h81);
        wait_write("rot_first", wd, t0); checkOutput("rot_first", wd, 32'h81);
        cpu_write(2'd0, 32'd1);
        wait_write("rot_1", wd, t0); checkOutput("rot_1", wd, 32'h03);
        wait_write("rot_2", wd, t1); checkOutput("rot_2", wd, 32'h06);
        checkOutput("rot_gap_2", 32'(t1 - t0), 32'd4);
        t0 = t1;
        wait_write("rot_3", wd, t1); checkOutput("rot_3", wd, 32'h0C);
        checkOutput("rot_gap_3", 32'(t1 - t0), 32'd4);

        // Bounce from 0x40 with PERIOD=1
        cpu_write(2'd0, 32'd0);
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd0, 32'd2);
        cpu_write(2'd2, 32'h40);
        wait_write("bnc_seed", wd, t0); checkOutput("bnc_seed", wd, 32'h40);
        cpu_write(2'd0, 32'd3);
        for (int k = 0; k < 9; k++) begin
            wait_write("bnc_step", wd, t1);
            checkOutput($sformatf("bnc_step%0d", k), wd, exp_seq[k]);
        end
        cpu_read(2'd3, rd); checkOutput("bnc_status", rd, 32'h5);

        // Rotate wrap after 8 steps from 0x01
        cpu_write(2'd0, 32'd0);
        cpu_write(2'd3, 32'd0);
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd2, 32'h01);
        wait_write("wrap_seed", wd, t0);
        cpu_write(2'd0, 32'd5);
        cpu_read(2'd0, rd); checkOutput("wrap_ctrl", rd, IRQ_BUILD ? 32'd5 : 32'd1);
        for (int k = 0; k < 8; k++) begin
            wait_write("wrap_step", wd, t1);
            checkOutput($sformatf("wrap_step%0d", k), wd, 32'd1 << ((k + 1) % 8));
            if (k == 6) begin
                cpu_read(2'd3, rd); checkOutput("wrap_before", rd, 32'h1);
            end
        end
        cpu_read(2'd3, rd); checkOutput("wrap_set", rd, 32'h5);
        checkOutput("wrap_irq", irq, IRQ_BUILD);
        cpu_write(2'd3, 32'd0);
        cpu_read(2'd3, rd); checkOutput("wrap_clear", rd, 32'h1);
        checkOutput("wrap_irq_clear", irq, 0);

        // PERIOD=0 stores 1; then a longer period and EN cleared mid-count
        cpu_write(2'd1, 32'd0);
        cpu_read(2'd1, rd); checkOutput("period_zero", rd, 32'd1);
        wait_write("p1_a", wd, t0);
        wait_write("p1_b", wd, t1);
        checkOutput("p1_gap", 32'(t1 - t0), 32'd2);
        cpu_write(2'd1, 32'd20);
        wait_write("p20_a", wd, t0);
        wait_write("p20_b", wd, t1);
        checkOutput("p20_gap", 32'(t1 - t0), 32'd21);
        repeat (5) tick();
        cpu_write(2'd0, 32'd0);
        tick();
        cpu_read(2'd3, rd); checkOutput("disable_busy", rd, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (pio_chipselect === 1'b1) pulses++;
            tick();
        end
        checkOutput("disable_no_writes", pulses, 0);

        // PATTERN write on the counter==0 cycle wins over the computed step
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd0, 32'd1);
        wait_write("coll_w", wd, t0);
        tick();
        tick();
        cpu_write(2'd2, 32'h5A);
        checkOutput("coll_cs", pio_chipselect, 1);
        checkOutput("coll_data", pio_writedata, 32'h5A);

        // Reset while the PIO write is on the bus
        reset = 1'b1;
        #1;
        checkOutput("rst_pio_cs", pio_chipselect, 0);
        checkOutput("rst_pio_wn", pio_write_n, 1);
        checkOutput("rst_pio_wd", pio_writedata, 0);
        cpu_read(2'd0, rd); checkOutput("rst_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); checkOutput("rst_period", rd, RESET_PERIOD_EX);
        cpu_read(2'd2, rd); checkOutput("rst_pattern", rd, 32'h0);
        cpu_read(2'd3, rd); checkOutput("rst_status", rd, 32'h0);
        @(negedge clk) reset = 1'b0;
        tick();

        // Randomized register traffic against the model
        applyStimulus(3000);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
